// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester byte-RAM arbiter: request record,
// arbiter state encoding and RAM geometry.
package mem_arb_pkg;

  localparam int MEM_ADDR_BITS = 2;
  localparam int MEM_DEPTH     = 2 ** MEM_ADDR_BITS;

  typedef struct packed {
    logic                     we;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [7:0]               wdata;
  } mem_req_t;

  typedef enum logic {
    RUN   = 1'b0,
    SWEEP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep request register for a single requester. Holds the captured
// request until the arbiter grants it; ready is low while it is occupied.
module mem_req_slot
  import mem_arb_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic                     i_we,
  input  logic [MEM_ADDR_BITS-1:0] i_addr,
  input  logic [7:0]               i_wdata,
  input  logic                     i_clear,
  output logic                     o_ready,
  output logic                     o_pend,
  output logic                     o_we,
  output logic [MEM_ADDR_BITS-1:0] o_addr,
  output logic [7:0]               o_wdata
);

  mem_req_t r_req;
  logic     r_pend;
  logic     w_accept;

  // A request is taken on valid & ready. ready depends only on registered
  // state, so a slot is never refilled in the cycle it is granted.
  assign o_ready  = i_enable & ~r_pend;
  assign w_accept = i_valid & o_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_req  <= '0;
    end else if (w_accept) begin
      r_pend <= 1'b1;
      r_req  <= '{we: i_we, addr: i_addr, wdata: i_wdata};
    end else if (i_clear) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend  = r_pend;
  assign o_we    = r_req.we;
  assign o_addr  = r_req.addr;
  assign o_wdata = r_req.wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port byte RAM.
// Optional MEM_ARB_ZERO_INIT_EN adds a post-reset sweep writing zeros.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int NUM_REQ   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_rvalid,
  output logic [7:0]           req0_rdata,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_rvalid,
  output logic [7:0]           req1_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 dbg_state
);

`ifdef MEM_ARB_ZERO_INIT_EN
  localparam arb_state_t RESET_STATE = SWEEP;
`else
  localparam arb_state_t RESET_STATE = RUN;
`endif

  arb_state_t                   r_state;
  arb_state_t                   w_state_next;
  logic [ADDR_BITS-1:0]         r_sweep_addr;
  logic [$clog2(NUM_REQ)-1:0]   r_rr_ptr;
  logic                         r_rvalid0;
  logic                         r_rvalid1;
  logic [7:0]                   r_rdata0;
  logic [7:0]                   r_rdata1;

  logic                         w_run;
  logic                         w_pend0;
  logic                         w_pend1;
  logic                         w_we0;
  logic                         w_we1;
  logic [ADDR_BITS-1:0]         w_addr0;
  logic [ADDR_BITS-1:0]         w_addr1;
  logic [7:0]                   w_wdata0;
  logic [7:0]                   w_wdata1;
  logic                         w_grant0;
  logic                         w_grant1;
  logic                         w_mem_we;
  logic [ADDR_BITS-1:0]         w_mem_addr;
  logic [7:0]                   w_mem_wdata;

  assign w_run = (r_state == RUN);

  mem_req_slot u_slot0 (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_run),
    .i_valid  (req0_valid),
    .i_we     (req0_we),
    .i_addr   (req0_addr),
    .i_wdata  (req0_wdata),
    .i_clear  (w_grant0),
    .o_ready  (req0_ready),
    .o_pend   (w_pend0),
    .o_we     (w_we0),
    .o_addr   (w_addr0),
    .o_wdata  (w_wdata0)
  );

  mem_req_slot u_slot1 (
    .clock    (clock),
    .reset    (reset),
    .i_enable (w_run),
    .i_valid  (req1_valid),
    .i_we     (req1_we),
    .i_addr   (req1_addr),
    .i_wdata  (req1_wdata),
    .i_clear  (w_grant1),
    .o_ready  (req1_ready),
    .o_pend   (w_pend1),
    .o_we     (w_we1),
    .o_addr   (w_addr1),
    .o_wdata  (w_wdata1)
  );

  // rr_ptr names the requester that wins when both are pending.
  assign w_grant0 = w_run & w_pend0 & (~w_pend1 | (r_rr_ptr == 1'b0));
  assign w_grant1 = w_run & w_pend1 & (~w_pend0 | (r_rr_ptr == 1'b1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SWEEP:   if (&r_sweep_addr) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sweep_addr <= '0;
    end else if (r_state == SWEEP) begin
      r_sweep_addr <= r_sweep_addr + 1'b1;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = 8'h00;
    if (r_state == SWEEP) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_sweep_addr;
    end else if (w_grant0) begin
      w_mem_we    = w_we0;
      w_mem_addr  = w_addr0;
      w_mem_wdata = w_wdata0;
    end else if (w_grant1) begin
      w_mem_we    = w_we1;
      w_mem_addr  = w_addr1;
      w_mem_wdata = w_wdata1;
    end
  end

  // The RAM writes on the same edge that applies reset, so gate the strobe.
  assign mem_we    = w_mem_we & reset;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rr_ptr  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 8'h00;
      r_rdata1  <= 8'h00;
    end else begin
      r_rvalid0 <= w_grant0 & ~w_we0;
      r_rvalid1 <= w_grant1 & ~w_we1;
      if (w_grant0 & ~w_we0) r_rdata0 <= mem_rdata;
      if (w_grant1 & ~w_we1) r_rdata1 <= mem_rdata;
      if (w_grant0 | w_grant1) r_rr_ptr <= w_grant0 ? 1'b1 : 1'b0;
    end
  end

  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;
  assign busy        = w_pend0 | w_pend1 | (r_state == SWEEP);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural byte RAM and per-requester
// read-data scoreboards. Honours MEM_ARB_ZERO_INIT_EN when defined.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [1:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [1:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic [1:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, dbg_state;

  logic [7:0] ram [4];
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] mon_e0, mon_e1;
  int         checks = 0;
  int         failures = 0;

`ifdef MEM_ARB_ZERO_INIT_EN
  localparam logic EXP_RST_READY = 1'b0;
  localparam logic EXP_RST_BUSY  = 1'b1;
  localparam logic EXP_RST_STATE = 1'b1;
`else
  localparam logic EXP_RST_READY = 1'b1;
  localparam logic EXP_RST_BUSY  = 1'b0;
  localparam logic EXP_RST_STATE = 1'b0;
`endif

  mem_arbiter #(.ADDR_BITS(2), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and RAM model
  always #5 clock = ~clock;
  assign mem_rdata = ram[mem_addr];
  always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Response scoreboard
  always @(negedge clock) begin
    if (reset && req0_rvalid) begin
      checks++;
      if (exp0_q.size() == 0) begin
        failures++;
        $display("FAIL rsp0_unexpected rdata=%h required no response", req0_rdata);
      end else begin
        mon_e0 = exp0_q.pop_front();
        if (req0_rdata !== mon_e0) begin
          failures++;
          $display("FAIL rsp0_data rdata=%h required %h", req0_rdata, mon_e0);
        end
      end
    end
    if (reset && req1_rvalid) begin
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL rsp1_unexpected rdata=%h required no response", req1_rdata);
      end else begin
        mon_e1 = exp1_q.pop_front();
        if (req1_rdata !== mon_e1) begin
          failures++;
          $display("FAIL rsp1_data rdata=%h required %h", req1_rdata, mon_e1);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [1:0] a, input logic [7:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [1:0] a, input logic [7:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!(req0_ready && req1_ready) && n < 40) begin
      tick;
      n++;
    end
    if (!(req0_ready && req1_ready)) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout ready=%b%b required 11 within 40 cycles", req0_ready, req1_ready);
    end
  endtask

  task automatic do_reset;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    wait_ready;
  endtask

  task automatic test_reset;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    reset = 1'b0;
    tick;
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req1_rvalid, req0_rdata, req1_rdata} !== 18'h0) begin
      failures++;
      $display("FAIL rst_resp rvalid=%b%b rdata=%h/%h required 00 00/00",
               req0_rvalid, req1_rvalid, req0_rdata, req1_rdata);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 2'd0) begin
      failures++;
      $display("FAIL rst_port we=%b addr=%0d required 0 0", mem_we, mem_addr);
    end
    checks++;
    if ({req0_ready, req1_ready, busy, dbg_state} !==
        {EXP_RST_READY, EXP_RST_READY, EXP_RST_BUSY, EXP_RST_STATE}) begin
      failures++;
      $display("FAIL rst_status ready=%b%b busy=%b state=%b required %b%b %b %b",
               req0_ready, req1_ready, busy, dbg_state,
               EXP_RST_READY, EXP_RST_READY, EXP_RST_BUSY, EXP_RST_STATE);
    end
    tick;
    reset = 1'b1;
    wait_ready;
  endtask

  task automatic test_write_read;
    drive0(1, 1, 2'd1, 8'hA5);
    @(negedge clock);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_ready ready=%b required 1", req0_ready);
    end
    tick;
    drive0(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd1, 8'hA5}) begin
      failures++;
      $display("FAIL wr_port we=%b addr=%0d wdata=%h required 1 1 a5", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({req0_ready, busy} !== 2'b01) begin
      failures++;
      $display("FAIL wr_pending ready=%b busy=%b required 0 1", req0_ready, busy);
    end
    tick;
    drive0(1, 0, 2'd1, 8'h00);
    exp0_q.push_back(8'hA5);
    tick;
    drive0(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if ({req0_rvalid, mem_we, mem_addr} !== {1'b0, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL rd_grant rvalid=%b we=%b addr=%0d required 0 0 1", req0_rvalid, mem_we, mem_addr);
    end
    tick;
    @(negedge clock);
    checks++;
    if (req0_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL rd_latency rvalid=%b required 1 two edges after accept", req0_rvalid);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req0_rdata} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL rd_hold rvalid=%b rdata=%h required 0 a5", req0_rvalid, req0_rdata);
    end
  endtask

  task automatic test_contention;
    do_reset;
    drive0(1, 1, 2'd0, 8'h3C);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    drive1(1, 1, 2'd3, 8'hC3);
    tick;
    drive1(0, 0, 0, 0);
    tick;
    drive0(1, 0, 2'd3, 8'h00);
    drive1(1, 0, 2'd0, 8'h00);
    exp0_q.push_back(8'hC3);
    exp1_q.push_back(8'h3C);
    tick;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if ({mem_we, mem_addr} !== {1'b0, 2'd3}) begin
      failures++;
      $display("FAIL rr_first we=%b addr=%0d required 0 3", mem_we, mem_addr);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req1_rvalid, mem_addr} !== {2'b10, 2'd0}) begin
      failures++;
      $display("FAIL rr_second rvalid=%b%b addr=%0d required 10 0", req0_rvalid, req1_rvalid, mem_addr);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req1_rvalid} !== 2'b01) begin
      failures++;
      $display("FAIL rr_third rvalid=%b%b required 01", req0_rvalid, req1_rvalid);
    end
    tick;
    drive0(1, 0, 2'd3, 8'h00);
    exp0_q.push_back(8'hC3);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    drive0(1, 0, 2'd3, 8'h00);
    drive1(1, 0, 2'd0, 8'h00);
    exp0_q.push_back(8'hC3);
    exp1_q.push_back(8'h3C);
    tick;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (mem_addr !== 2'd0) begin
      failures++;
      $display("FAIL rr_swap_first addr=%0d required 0", mem_addr);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req1_rvalid} !== 2'b01) begin
      failures++;
      $display("FAIL rr_swap_order rvalid=%b%b required 01", req0_rvalid, req1_rvalid);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({req0_rvalid, req1_rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL rr_swap_last rvalid=%b%b required 10", req0_rvalid, req1_rvalid);
    end
    tick;
  endtask

  task automatic test_same_addr;
    do_reset;
    drive0(1, 1, 2'd2, 8'h11);
    drive1(1, 1, 2'd2, 8'h22);
    tick;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd2, 8'h11}) begin
      failures++;
      $display("FAIL waw_first we=%b addr=%0d wdata=%h required 1 2 11", mem_we, mem_addr, mem_wdata);
    end
    tick;
    @(negedge clock);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd2, 8'h22}) begin
      failures++;
      $display("FAIL waw_second we=%b addr=%0d wdata=%h required 1 2 22", mem_we, mem_addr, mem_wdata);
    end
    tick;
    checks++;
    if (ram[2] !== 8'h22) begin
      failures++;
      $display("FAIL waw_ram ram2=%h required 22", ram[2]);
    end
    drive0(1, 0, 2'd2, 8'h00);
    exp0_q.push_back(8'h22);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    drive0(1, 0, 2'd1, 8'h00);
    drive1(1, 1, 2'd1, 8'h5A);
    exp0_q.push_back(8'h5A);
    tick;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd1, 8'h5A}) begin
      failures++;
      $display("FAIL raw_write we=%b addr=%0d wdata=%h required 1 1 5a", mem_we, mem_addr, mem_wdata);
    end
    tick;
    tick;
    @(negedge clock);
    checks++;
    if (req0_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL raw_read rvalid=%b required 1", req0_rvalid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int   pulses;
    logic exp_ready, exp_rv;
    pulses = 0;
    drive0(1, 0, 2'd2, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      exp_ready = (k % 2 == 0);
      exp_rv    = (k >= 2) && (k % 2 == 0);
      checks++;
      if ({req0_ready, req0_rvalid} !== {exp_ready, exp_rv}) begin
        failures++;
        $display("FAIL b2b_k%0d ready=%b rvalid=%b required %b %b",
                 k, req0_ready, req0_rvalid, exp_ready, exp_rv);
      end
      if (exp_ready) exp0_q.push_back(8'h22);
      if (req0_rvalid) pulses++;
      tick;
    end
    drive0(0, 0, 0, 0);
    for (int k = 8; k < 12; k++) begin
      @(negedge clock);
      if (req0_rvalid) pulses++;
      tick;
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL b2b_pulses count=%0d required 4", pulses);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    drive0(1, 1, 2'd0, 8'h77);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    drive0(1, 0, 2'd0, 8'h00);
    exp0_q.push_back(8'h77);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    drive0(1, 1, 2'd0, 8'hEE);
    drive1(1, 1, 2'd3, 8'hDD);
    tick;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({mem_we, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_we we=%b busy=%b required 0 1", mem_we, busy);
    end
    tick;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_rdata} !==
        {EXP_RST_READY, EXP_RST_READY, 2'b00, 8'h00}) begin
      failures++;
      $display("FAIL rstmid_state ready=%b%b rvalid=%b%b rdata0=%h required %b%b 00 00",
               req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_rdata,
               EXP_RST_READY, EXP_RST_READY);
    end
`ifndef MEM_ARB_ZERO_INIT_EN
    checks++;
    if ({busy, ram[0], ram[3]} !== {1'b0, 8'h77, 8'hC3}) begin
      failures++;
      $display("FAIL rstmid_ram busy=%b ram0=%h ram3=%h required 0 77 c3", busy, ram[0], ram[3]);
    end
`endif
    wait_ready;
  endtask

`ifdef MEM_ARB_ZERO_INIT_EN
  task automatic test_sweep;
    drive0(1, 1, 2'd3, 8'hFF);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({mem_we, mem_addr, mem_wdata, req0_ready, req1_ready, busy} !==
          {1'b1, 2'(i), 8'h00, 2'b00, 1'b1}) begin
        failures++;
        $display("FAIL sweep_c%0d we=%b addr=%0d wdata=%h ready=%b%b busy=%b required 1 %0d 00 00 1",
                 i, mem_we, mem_addr, mem_wdata, req0_ready, req1_ready, busy, i);
      end
      tick;
    end
    @(negedge clock);
    checks++;
    if ({req0_ready, busy, mem_we} !== 3'b100) begin
      failures++;
      $display("FAIL sweep_done ready=%b busy=%b we=%b required 1 0 0", req0_ready, busy, mem_we);
    end
    tick;
    drive0(1, 0, 2'd3, 8'h00);
    exp0_q.push_back(8'h00);
    tick;
    drive0(0, 0, 0, 0);
    tick;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_contention;
    test_same_addr;
    test_back_to_back;
    test_reset_mid;
`ifdef MEM_ARB_ZERO_INIT_EN
    test_sweep;
`endif
    repeat (4) tick;
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      failures++;
      $display("FAIL drain left0=%0d left1=%0d required 0 0", exp0_q.size(), exp1_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port byte RAM in memory_block (combinational read, write on clock edge with we). Each requester posts a read or write into a 1-deep request register. The arbiter grants one request per cycle, round-robin, and drives the RAM port. Read data returns on a registered per-requester response channel, so neither requester sees a combinational path to the RAM.

Parameters:
ADDR_BITS, 2, RAM address width; depth = 2**ADDR_BITS bytes
NUM_REQ, 2, number of requesters; fixed at 2 in this revision

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-low reset
req0_valid  input  1  requester 0 request strobe
req0_we  input  1  1 = write, 0 = read
req0_addr  input  ADDR_BITS  requester 0 address
req0_wdata  input  8  requester 0 write data
req0_ready  output  1  requester 0 request register empty; request accepted when valid & ready
req0_rvalid  output  1  one-cycle pulse: req0_rdata valid
req0_rdata  output  8  read response for requester 0
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as requester 0
mem_addr  output  ADDR_BITS  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  8  RAM write data
mem_rdata  input  8  RAM combinational read data
busy  output  1  any request pending or sweep in progress

Behaviour:
- Reset (reset==0 at posedge):
  - pend0 = pend1 = 0; rr_ptr = 0 (requester 0 preferred first).
  - reqN_rvalid = 0; reqN_rdata = 8'h00.
  - Without the optional feature, state = RUN.
- Accept:
  - reqN_ready = !pendN (combinational from register).
  - On valid & ready, capture we/addr/wdata into pendN; pendN = 1 next cycle.
- Grant: in cycle T with both pending, grant requester rr_ptr; with one pending, grant it.
  - Combinationally drive mem_addr/mem_we/mem_wdata from the granted register.
  - mem_we = granted_we only; with no grant, mem_we = 0 and mem_addr = 0.
- Completion at posedge ending cycle T:
  - Clear granted pendN.
  - rr_ptr = !granted index; rr_ptr changes only on a grant.
  - Read: reqN_rdata = mem_rdata sampled at that edge; reqN_rvalid = 1 for exactly one cycle.
  - Write: no response pulse.
- Latency:
  - Uncontended request accepted at edge E0 is granted in cycle E0→E1; read response is visible after E1.
  - Accept-to-rvalid = 2 edges.
  - Contended loser waits at most one extra cycle.
- Throughput: one RAM access per cycle. Each requester gets at most one access per 2 cycles, because ready is low while its own request is pending (no enqueue-same-cycle-as-dequeue).
- Simultaneous events:
  - Both requesters writing the same address in back-to-back grants: later grant wins.
  - Read granted the cycle after a write to the same address returns the new data.
- reqN_rdata holds its last value when rvalid = 0.
- Reset mid-operation drops pending requests; no RAM write occurs in the reset cycle (mem_we forced 0 while reset==0).
- busy = pend0 | pend1 | (state==SWEEP).

Optional Feature:
MEM_ARB_ZERO_INIT_EN
- Defined:
  - Reset enters state SWEEP with sweep_addr = 0.
  - Each cycle: mem_we = 1, mem_addr = sweep_addr, mem_wdata = 0; sweep_addr increments.
  - After writing address 2**ADDR_BITS-1, state moves to RUN.
  - During SWEEP both ready = 0 and no grants occur.
  - Sweep takes exactly 2**ADDR_BITS cycles after reset deasserts.
- Undefined: no SWEEP state; ready = 1 the first cycle after reset; RAM contents are undefined until written.

Decomposition:
- Package mem_arb_pkg:
  - typedef mem_req_t {we, addr[ADDR_BITS-1:0], wdata[7:0]}.
  - State enum {RUN, SWEEP}.
  - Localparam MEM_DEPTH = 2**ADDR_BITS.
- One sub-module, mem_req_slot: holds the 1-deep request register, ready, and the clear-on-grant logic; instantiated twice.
- Arbitration, RAM port mux and response registers stay in mem_arbiter.

Test Plan:
- Reset then req0 write addr 1 data 8'hA5 → mem_we=1, mem_addr=1 one cycle after accept; req0 read addr 1 → req0_rvalid pulse 2 edges after accept, rdata=8'hA5.
- Both requesters read in the same cycle, rr_ptr=0 → req0 granted first and rvalid one cycle before req1; next simultaneous pair → req1 granted first.
- req0 writes addr 2 = 8'h11 and req1 writes addr 2 = 8'h22 simultaneously with rr_ptr=0 → final RAM[2]=8'h22; a subsequent read returns 8'h22.
- Hold req0_valid high continuously with reads → req0_ready toggles 1,0,1,0; rvalid pulses every 2 cycles; no duplicate accepts.
- Assert reset while both pending → next cycle pend cleared, ready=1, no rvalid, mem_we=0 during reset.
- With MEM_ARB_ZERO_INIT_EN (ADDR_BITS=2) → 4 sweep writes of 0 to addrs 0..3, ready=0 for 4 cycles, then a read of addr 3 returns 8'h00.
